// File: rtl/i2c_reg_seq.sv
// Register-access sequencer for an i2c_master_top core: one-time core init, then
// single-byte register writes/reads over I2C with NACK and timeout reporting.
module i2c_reg_seq #(
  parameter logic [15:0] PRESCALE = 16'h0064,
  parameter logic [19:0] TIMEOUT  = 20'hFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_sadr,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [15:0] m_prer_o,
  output logic [7:0]  m_ctr_o,
  output logic [7:0]  m_txr_o,
  output logic [7:0]  m_cr_o,
  output logic        m_cs_o,
  input  logic        m_ack_i,
  input  logic [7:0]  m_sr_i,
  input  logic [7:0]  m_rxr_i
);

  typedef enum logic [3:0] {
    S_INIT_PRER = 4'd0,
    S_INIT_CTR  = 4'd1,
    S_IDLE      = 4'd2,
    S_CMD       = 4'd3,
    S_POLL      = 4'd4,
    S_CHECK     = 4'd5,
    S_STOP_CMD  = 4'd6,
    S_STOP_POLL = 4'd7,
    S_RESP      = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        rw_q, rw_d;
  logic [6:0]  sadr_q, sadr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready_q, req_ready_d;
  logic [15:0] prer_q, prer_d;
  logic [7:0]  ctr_q, ctr_d;
  logic [7:0]  txr_q, txr_d;
  logic [7:0]  cr_q, cr_d;
  logic        cs_q, cs_d;

  logic        acked_s;
  logic        tmo_s;
  logic        tip_s;
  logic        rxnack_s;
  logic        last_step_s;
  logic        skip_ack_s;
  logic [7:0]  step_txr_s;
  logic [7:0]  step_cr_s;
  logic        sr_unused_s;

  // An ack only counts while our own strobe is up, so a late ack never leaks into the next access.
  assign acked_s     = cs_q & m_ack_i;
  assign tmo_s       = (cnt_q == TIMEOUT);
  assign tip_s       = m_sr_i[1];
  assign rxnack_s    = m_sr_i[7];
  assign last_step_s = rw_q ? (step_q == 2'd3) : (step_q == 2'd2);
  assign skip_ack_s  = rw_q & (step_q == 2'd3);
  assign sr_unused_s = ^{m_sr_i[6:2], m_sr_i[0]};

  // Transmit byte and command byte for the current step of the transaction.
  always_comb begin
    step_txr_s = txr_q;
    step_cr_s  = 8'h00;
    case (step_q)
      2'd0: begin
        step_txr_s = {sadr_q, 1'b0};
        step_cr_s  = 8'h90;
      end
      2'd1: begin
        step_txr_s = addr_q;
        step_cr_s  = 8'h10;
      end
      2'd2: begin
        step_txr_s = rw_q ? {sadr_q, 1'b1} : wdata_q;
        step_cr_s  = rw_q ? 8'h90 : 8'h50;
      end
      2'd3: begin
        step_txr_s = txr_q;
        step_cr_s  = 8'h68;
      end
      default: begin
        step_txr_s = txr_q;
        step_cr_s  = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_INIT_PRER;
      step_q      <= 2'd0;
      rw_q        <= 1'b0;
      sadr_q      <= 7'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      cnt_q       <= 20'd0;
      rdata_q     <= 8'd0;
      err_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      prer_q      <= 16'd0;
      ctr_q       <= 8'd0;
      txr_q       <= 8'd0;
      cr_q        <= 8'd0;
      cs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      sadr_q      <= sadr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      prer_q      <= prer_d;
      ctr_q       <= ctr_d;
      txr_q       <= txr_d;
      cr_q        <= cr_d;
      cs_q        <= cs_d;
    end
  end

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rw_d    = rw_q;
    sadr_d  = sadr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_INIT_PRER: begin
        if (acked_s) state_d = S_INIT_CTR;
        else         state_d = S_INIT_PRER;
      end
      S_INIT_CTR: begin
        if (acked_s) state_d = S_IDLE;
        else         state_d = S_INIT_CTR;
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          rw_d    = req_rw;
          sadr_d  = req_sadr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          step_d  = 2'd0;
          rdata_d = 8'd0;
          err_d   = 2'd0;
          state_d = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (acked_s) begin
          cnt_d   = 20'd0;
          state_d = S_POLL;
        end else begin
          state_d = S_CMD;
        end
      end
      S_POLL: begin
        if (tmo_s) begin
          err_d[1] = 1'b1;
          state_d  = S_STOP_CMD;
        end else begin
          cnt_d = cnt_q + 20'd1;
          if (acked_s && !tip_s) state_d = S_CHECK;
          else                   state_d = S_POLL;
        end
      end
      S_CHECK: begin
        if (!skip_ack_s && rxnack_s) begin
          err_d[0] = 1'b1;
          state_d  = S_STOP_CMD;
        end else if (last_step_s) begin
          if (rw_q) rdata_d = m_rxr_i;
          else      rdata_d = 8'd0;
          state_d = S_RESP;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = S_CMD;
        end
      end
      S_STOP_CMD: begin
        if (acked_s) begin
          cnt_d   = 20'd0;
          state_d = S_STOP_POLL;
        end else begin
          state_d = S_STOP_CMD;
        end
      end
      S_STOP_POLL: begin
        // A stop that never completes is reported, not retried.
        if (tmo_s) begin
          err_d[1] = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 20'd1;
          if (acked_s && !tip_s) state_d = S_RESP;
          else                   state_d = S_STOP_POLL;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT_PRER;
    endcase
  end

  // Next values of the registered core-side and handshake outputs.
  always_comb begin
    prer_d = prer_q;
    ctr_d  = ctr_q;
    txr_d  = txr_q;
    cr_d   = cr_q;
    cs_d   = 1'b0;
    case (state_q)
      S_INIT_PRER: begin
        prer_d = PRESCALE;
        cs_d   = ~acked_s;
      end
      S_INIT_CTR: begin
        ctr_d = 8'h80;
        cs_d  = ~acked_s;
      end
      S_CMD: begin
        txr_d = step_txr_s;
        cr_d  = step_cr_s;
        cs_d  = ~acked_s;
      end
      S_POLL, S_STOP_POLL: begin
        cr_d = 8'h00;
        cs_d = ~acked_s & ~tmo_s;
      end
      S_STOP_CMD: begin
        cr_d = 8'h40;
        cs_d = ~acked_s;
      end
      default: cs_d = 1'b0;
    endcase
    rsp_valid_d = (state_d == S_RESP);
    req_ready_d = (state_d == S_IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_prer_o  = prer_q;
  assign m_ctr_o   = ctr_q;
  assign m_txr_o   = txr_q;
  assign m_cr_o    = cr_q;
  assign m_cs_o    = cs_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a behavioural i2c core + slave at 7'h10 answers the
// register strobes; responses are checked by a queue-based scoreboard.
module tb_i2c_reg_seq;
  localparam int         BYTE_T = 30;
  localparam logic [6:0] SLV    = 7'h10;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        req_valid, req_ready, req_rw;
  logic [6:0]  req_sadr;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic [15:0] m_prer_o;
  logic [7:0]  m_ctr_o, m_txr_o, m_cr_o;
  logic        m_cs_o, m_ack_i;
  logic [7:0]  m_sr_i, m_rxr_i;

  always #10 clk = ~clk;

  i2c_reg_seq #(.PRESCALE(16'h0064), .TIMEOUT(20'd1000)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_sadr(req_sadr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_prer_o(m_prer_o), .m_ctr_o(m_ctr_o), .m_txr_o(m_txr_o), .m_cr_o(m_cr_o),
    .m_cs_o(m_cs_o), .m_ack_i(m_ack_i), .m_sr_i(m_sr_i), .m_rxr_i(m_rxr_i)
  );

  // Core + slave model
  logic        ack_m, rxack_m, addressed_m, dir_m, stall;
  logic [7:0]  rxr_m, ptr_m;
  int          tip_cnt, byte_idx;
  logic [7:0]  mem [0:255];
  logic [7:0]  cr_log [$];
  logic [31:0] acc_log [$];

  assign m_ack_i = ack_m;
  assign m_sr_i  = {rxack_m, 5'b00000, (tip_cnt != 0), 1'b0};
  assign m_rxr_i = rxr_m;

  always @(posedge clk) begin
    if (!wb_rst_i) begin
      ack_m <= 1'b0; tip_cnt <= 0; rxack_m <= 1'b0; rxr_m <= 8'h00;
      addressed_m <= 1'b0; dir_m <= 1'b0; byte_idx <= 0; ptr_m <= 8'h00;
    end else begin
      ack_m <= m_cs_o & ~ack_m;
      if (!stall && tip_cnt > 0) tip_cnt <= tip_cnt - 1;
      if (m_cs_o && !ack_m) begin
        acc_log.push_back({m_prer_o, m_ctr_o, m_cr_o});
        if (m_cr_o != 8'h00) begin
          cr_log.push_back(m_cr_o);
          tip_cnt <= BYTE_T;
          if (m_cr_o[4]) begin
            if (m_cr_o[7]) begin
              addressed_m <= (m_txr_o[7:1] == SLV);
              dir_m       <= m_txr_o[0];
              rxack_m     <= (m_txr_o[7:1] != SLV);
              byte_idx    <= 1;
            end else begin
              rxack_m <= ~addressed_m;
              if (addressed_m && !dir_m) begin
                if (byte_idx == 1) ptr_m <= m_txr_o;
                else begin
                  mem[ptr_m] <= m_txr_o;
                  ptr_m      <= ptr_m + 8'd1;
                end
              end
              byte_idx <= byte_idx + 1;
            end
          end else if (m_cr_o[5]) begin
            rxr_m <= mem[ptr_m];
            ptr_m <= ptr_m + 8'd1;
          end
        end
      end
    end
  end

  int checks = 0, fails = 0, rsp_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Scoreboard: expected {rdata, err} pushed at issue, popped on each response.
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== mon_e) begin
          fails++;
          $display("FAIL rsp got rdata=%h err=%b expected rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e[9:2], mon_e[1:0]);
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [6:0] sadr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] e_rd, input logic [1:0] e_err);
    int n = 0;
    exp_q.push_back({e_rd, e_err});
    @(negedge clk);
    req_rw = rw; req_sadr = sadr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (!req_ready && n < 5000) begin @(negedge clk); n++; end
    check("req_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int budget);
    int start = rsp_cnt;
    int n = 0;
    while (rsp_cnt == start && n < budget) begin @(negedge clk); n++; end
    check(name, rsp_cnt - start, 1);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check(name, req_ready, 1'b1);
  endtask

  task automatic check_cr(input string name, input int n, input logic [31:0] exp);
    logic [31:0] v = 32'h0;
    foreach (cr_log[i]) v = {v[23:0], cr_log[i]};
    check(name, {24'h0, 8'(cr_log.size()), v}, {24'h0, 8'(n), exp});
  endtask

  task automatic check_init(input string name);
    check({name, "_cnt"}, acc_log.size() >= 2, 1'b1);
    if (acc_log.size() >= 2) begin
      check({name, "_prer"}, acc_log[0], {16'h0064, 8'h00, 8'h00});
      check({name, "_ctr"},  acc_log[1], {16'h0064, 8'h80, 8'h00});
    end
  endtask

  int pre_cnt;
  initial begin
    wb_rst_i = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
    req_sadr = 7'h00; req_addr = 8'h00; req_wdata = 8'h00; stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cs", m_cs_o, 1'b0);
    check("rst_regs", {m_prer_o, m_ctr_o, m_txr_o, m_cr_o, rsp_rdata, rsp_err},
          {16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 2'b00});
    wb_rst_i = 1'b1;

    // 1: init then ready
    wait_ready("init_ready");
    check_init("init");

    // 2: write A5 to reg 1
    cr_log.delete();
    issue(1'b0, SLV, 8'h01, 8'hA5, 8'h00, 2'b00);
    wait_rsp("wr_rsp_seen", 2000);
    check_cr("wr_cr_seq", 3, 32'h00901050);
    check("wr_mem1", mem[1], 8'hA5);

    // 3: read reg 1
    wait_ready("rd_ready");
    cr_log.delete();
    issue(1'b1, SLV, 8'h01, 8'h00, 8'hA5, 2'b00);
    wait_rsp("rd_rsp_seen", 2000);
    check_cr("rd_cr_seq", 4, 32'h90109068);

    // 4: absent slave -> NACK, stop
    wait_ready("nack_ready");
    cr_log.delete();
    issue(1'b0, 7'h11, 8'h01, 8'h77, 8'h00, 2'b01);
    wait_rsp("nack_rsp_seen", 2000);
    check_cr("nack_cr_seq", 2, 32'h00009040);
    check("nack_mem1", mem[1], 8'hA5);

    // 5: bus stuck -> timeout in both poll phases
    wait_ready("tmo_pre_ready");
    cr_log.delete();
    stall = 1'b1;
    issue(1'b0, SLV, 8'h03, 8'h55, 8'h00, 2'b10);
    wait_rsp("tmo_rsp_within_2200", 2200);
    check_cr("tmo_cr_seq", 2, 32'h00009040);
    stall = 1'b0;
    wait_ready("tmo_idle");
    repeat (BYTE_T + 5) @(negedge clk);

    // 6: reset mid-read drops the request and re-initialises
    cr_log.delete();
    issue(1'b1, SLV, 8'h01, 8'h00, 8'hA5, 2'b00);
    begin
      int n = 0;
      while (cr_log.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    end
    check("mid_rd_progress", cr_log.size() >= 2, 1'b1);
    void'(exp_q.pop_back());
    pre_cnt = rsp_cnt;
    acc_log.delete();
    wb_rst_i = 1'b0;
    @(negedge clk);
    wb_rst_i = 1'b1;
    wait_ready("reinit_ready");
    check("no_rsp_after_reset", rsp_cnt, pre_cnt);
    check_init("reinit");
    issue(1'b0, SLV, 8'h02, 8'h3C, 8'h00, 2'b00);
    wait_rsp("post_rst_rsp_seen", 2000);
    check("post_rst_mem2", mem[2], 8'h3C);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
